// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the single-port RAM round-robin arbiter.
package spram_arb_pkg;

    typedef enum logic {
        INIT,
        SERVE
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: one-hot combinational grant, tie-break pointer
// advances only on an actual grant.
module rr_arbiter2
    import spram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // High when B wins a tie, i.e. A was granted most recently.
    logic prio_b_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[REQ_A] && (!req[REQ_B] || !prio_b_q)) begin
                gnt[REQ_A] = 1'b1;
            end else if (req[REQ_B]) begin
                gnt[REQ_B] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b_q <= 1'b0;
        end else if (gnt[REQ_A]) begin
            prio_b_q <= 1'b1;
        end else if (gnt[REQ_B]) begin
            prio_b_q <= 1'b0;
        end
    end

endmodule

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one registered-address single-port RAM between two
// requesters, with optional post-reset zero-fill. SPRAM_ARB_STATS_EN adds grant counters.
module spram_rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              init_done
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] gcnt_a,
    output logic [STATS_W-1:0] gcnt_b
`endif
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [1:0]          gnt;
    logic [1:0]          rd_pend_q;
    logic [1:0]          rvalid_q;
    logic [DATA_W-1:0]   rdata_a_q, rdata_b_q;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  ((state_q == SERVE) && !rst),
        .req ({req_b, req_a}),
        .gnt (gnt)
    );

    assign gnt_a     = gnt[REQ_A];
    assign gnt_b     = gnt[REQ_B];
    assign rvalid_a  = rvalid_q[REQ_A];
    assign rvalid_b  = rvalid_q[REQ_B];
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign init_done = (state_q == SERVE) && !rst;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        ram_we      = 1'b0;
        ram_addr    = addr_hold_q;
        ram_wdata   = '0;
        case (state_q)
            INIT: begin
                ram_we      = 1'b1;
                ram_addr    = init_addr_q;
                init_addr_d = init_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (init_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (gnt[REQ_A]) begin
                    ram_we    = we_a;
                    ram_addr  = addr_a;
                    ram_wdata = wdata_a;
                end else if (gnt[REQ_B]) begin
                    ram_we    = we_b;
                    ram_addr  = addr_b;
                    ram_wdata = wdata_b;
                end
            end
            default: state_d = SERVE;
        endcase
        // Reset is synchronous, so quiet the RAM port combinationally while it is held.
        if (rst) begin
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? INIT : SERVE;
            init_addr_q <= '0;
            addr_hold_q <= '0;
            rd_pend_q   <= 2'b00;
            rvalid_q    <= 2'b00;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            if ((state_q == INIT) || (gnt != 2'b00)) begin
                addr_hold_q <= ram_addr;
            end
            // Stage 1: read granted; stage 2: RAM data captured and pulsed out.
            rd_pend_q <= gnt & ~{we_b, we_a};
            rvalid_q  <= rd_pend_q;
            if (rd_pend_q[REQ_A]) begin
                rdata_a_q <= ram_rdata;
            end
            if (rd_pend_q[REQ_B]) begin
                rdata_b_q <= ram_rdata;
            end
        end
    end

`ifdef SPRAM_ARB_STATS_EN
    logic [STATS_W-1:0] gcnt_a_q, gcnt_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_a_q <= '0;
            gcnt_b_q <= '0;
        end else begin
            if (gnt[REQ_A] && (gcnt_a_q != {STATS_W{1'b1}})) begin
                gcnt_a_q <= gcnt_a_q + {{(STATS_W-1){1'b0}}, 1'b1};
            end
            if (gnt[REQ_B] && (gcnt_b_q != {STATS_W{1'b1}})) begin
                gcnt_b_q <= gcnt_b_q + {{(STATS_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign gcnt_a = gcnt_a_q;
    assign gcnt_b = gcnt_b_q;
`endif

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed self-checking bench for spram_rr_arbiter with a behavioural
// registered-address RAM; exercises grant counters when SPRAM_ARB_STATS_EN is defined.
module tb_spram_rr_arbiter;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_a, req_b, we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              init_done;
`ifdef SPRAM_ARB_STATS_EN
    logic [15:0]       gcnt_a, gcnt_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spram_rr_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .wdata_a   (wdata_a),
        .wdata_b   (wdata_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .rvalid_a  (rvalid_a),
        .rvalid_b  (rvalid_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .init_done (init_done)
`ifdef SPRAM_ARB_STATS_EN
        ,
        .gcnt_a    (gcnt_a),
        .gcnt_b    (gcnt_b)
`endif
    );

    // Registered-address RAM: data for an address sampled at edge N is visible after it.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] mem_addr_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        mem_addr_q <= ram_addr;
    end
    assign ram_rdata = mem[mem_addr_q];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

        // Held in reset with a pending request: nothing may be granted or driven.
        repeat (2) @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'd9; wdata_a = 32'h1234_5678;
        #1;
        chk("rst_gnt_a", gnt_a, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_rvalid_a", rvalid_a, 1'b0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_rdata_b", rdata_b, 0);

        // First sweep, interrupted at address 20; requests are ignored during INIT.
        @(negedge clk); rst = 1'b0; #1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk("init1_addr", ram_addr, i);
            chk("init1_we", ram_we, 1'b1);
            chk("init1_gnt_a", gnt_a, 1'b0);
            chk("init1_done", init_done, 1'b0);
        end
        @(negedge clk); #1;
        chk("init1_addr20", ram_addr, 20);
        rst = 1'b1; #1;
        chk("init_rst_we", ram_we, 1'b0);

        // Restarted sweep covers 0..63 with zero data, then SERVE.
        @(negedge clk); rst = 1'b0; req_a = 1'b0; we_a = 1'b0; #1;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk("init2_addr", ram_addr, i);
            chk("init2_we", ram_we, 1'b1);
            chk("init2_wdata", ram_wdata, 0);
            chk("init2_done", init_done, 1'b0);
        end
        @(negedge clk); #1;
        chk("init_done_rise", init_done, 1'b1);
        chk("idle_ram_we", ram_we, 1'b0);
        chk("idle_addr_hold", ram_addr, 63);

        // A writes 0xDEADBEEF @5, then reads it back.
        @(negedge clk); req_a = 1'b1; we_a = 1'b1; addr_a = 6'd5; wdata_a = 32'hDEAD_BEEF; #1;
        chk("wr_gnt_a", gnt_a, 1'b1);
        chk("wr_gnt_b", gnt_b, 1'b0);
        chk("wr_ram_we", ram_we, 1'b1);
        chk("wr_ram_addr", ram_addr, 5);
        chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        @(negedge clk); we_a = 1'b0; #1;
        chk("rd_gnt_a", gnt_a, 1'b1);
        chk("rd_ram_we", ram_we, 1'b0);
        chk("rd_ram_addr", ram_addr, 5);
        @(negedge clk); req_a = 1'b0; addr_a = 6'd9; #1;
        chk("rd_n1_gnt_a", gnt_a, 1'b0);
        chk("rd_n1_addr_hold", ram_addr, 5);
        chk("rd_n1_rvalid_a", rvalid_a, 1'b0);
        @(negedge clk); #1;
        chk("rd_n2_rvalid_a", rvalid_a, 1'b1);
        chk("rd_n2_rdata_a", rdata_a, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        chk("rd_n3_rvalid_a", rvalid_a, 1'b0);
        chk("rd_n3_rdata_hold", rdata_a, 32'hDEAD_BEEF);

        // B alone writes 0x11111111 @7 and is granted immediately.
        @(negedge clk); req_b = 1'b1; we_b = 1'b1; addr_b = 6'd7; wdata_b = 32'h1111_1111; #1;
        chk("wrb_gnt_b", gnt_b, 1'b1);
        chk("wrb_gnt_a", gnt_a, 1'b0);
        chk("wrb_ram_addr", ram_addr, 7);
        chk("wrb_rvalid_b", rvalid_b, 1'b0);

        // Both read for 6 cycles: last grant was B, so A,B,A,B,A,B.
        @(negedge clk); we_b = 1'b0; addr_a = 6'd5; req_a = 1'b1; req_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 6) begin req_a = 1'b0; req_b = 1'b0; end
            #1;
            if (k < 6) begin
                chk("alt_gnt_a", gnt_a, (k % 2) == 0);
                chk("alt_gnt_b", gnt_b, (k % 2) == 1);
            end
            if (k >= 2) begin
                chk("alt_rvalid_a", rvalid_a, (k % 2) == 0);
                chk("alt_rvalid_b", rvalid_b, (k % 2) == 1);
                if ((k % 2) == 0) chk("alt_rdata_a", rdata_a, 32'hDEAD_BEEF);
                else              chk("alt_rdata_b", rdata_b, 32'h1111_1111);
            end
        end

        // Only B for 4 cycles: granted every cycle, 4 consecutive rvalid_b pulses.
        @(negedge clk); req_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) req_b = 1'b0;
            #1;
            if (k < 4) chk("bonly_gnt_b", gnt_b, 1'b1);
            chk("bonly_rvalid_b", rvalid_b, (k >= 2) && (k < 6));
            if ((k >= 2) && (k < 6)) chk("bonly_rdata_b", rdata_b, 32'h1111_1111);
        end

        // Tie after B's streak goes to A; B then follows once A drops.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'd10; wdata_a = 32'hA5A5_A5A5;
        req_b = 1'b1; we_b = 1'b1; addr_b = 6'd11; wdata_b = 32'h5A5A_5A5A; #1;
        chk("tie_gnt_a", gnt_a, 1'b1);
        chk("tie_gnt_b", gnt_b, 1'b0);
        chk("tie_ram_addr", ram_addr, 10);
        @(negedge clk); req_a = 1'b0; #1;
        chk("tie2_gnt_b", gnt_b, 1'b1);
        chk("tie2_ram_wdata", ram_wdata, 32'h5A5A_5A5A);
        @(negedge clk); req_b = 1'b0; we_a = 1'b0; we_b = 1'b0; #1;
        chk("tie3_ram_we", ram_we, 1'b0);

        // Reset the cycle after a read grant: the pending pulse is discarded.
        @(negedge clk); req_a = 1'b1; addr_a = 6'd5; #1;
        chk("rstrd_gnt_a", gnt_a, 1'b1);
        @(negedge clk); req_a = 1'b0; rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; #1;
        chk("rstrd_rvalid_a", rvalid_a, 1'b0);
        chk("rstrd_rdata_a", rdata_a, 0);
        chk("rstrd_init_done", init_done, 1'b0);

`ifdef SPRAM_ARB_STATS_EN
        repeat (64) @(negedge clk);
        #1;
        chk("stats_init_done", init_done, 1'b1);
        chk("stats_cleared", gcnt_a, 0);
        req_a = 1'b1;
        repeat (70000) @(negedge clk);
        #1;
        chk("stats_gcnt_a_sat", gcnt_a, 16'hFFFF);
        chk("stats_gcnt_b", gcnt_b, 0);
        req_a = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_rr_arbiter.md
SPRAM_RR_ARBITER -- requirements
Module: spram_rr_arbiter

Interface
REQ-001 Parameter: ADDR_W, 6, RAM address width (depth 2^ADDR_W).
REQ-002 Parameter: DATA_W, 32, RAM data width.
REQ-003 Parameter: CLEAR_ON_RESET, 1, nonzero enables post-reset zero-fill sweep.
REQ-004 Port: clk  input  1  clock, all logic on rising edge.
REQ-005 Port: rst  input  1  reset rst, synchronous, active-high.
REQ-006 Ports: req_a / req_b  input  1  requester access request, held until granted.
REQ-007 Ports: we_a / we_b  input  1  1=write, 0=read; stable while req high.
REQ-008 Ports: addr_a / addr_b  input  ADDR_W  access address.
REQ-009 Ports: wdata_a / wdata_b  input  DATA_W  write data.
REQ-010 Ports: gnt_a / gnt_b  output  1  grant; transfer occurs in cycle where req&gnt.
REQ-011 Ports: rvalid_a / rvalid_b  output  1  one-cycle pulse, read data valid.
REQ-012 Ports: rdata_a / rdata_b  output  DATA_W  registered read data.
REQ-013 Port: ram_we  output  1  RAM write enable.
REQ-014 Port: ram_addr  output  ADDR_W  RAM address.
REQ-015 Port: ram_wdata  output  DATA_W  RAM write data.
REQ-016 Port: ram_rdata  input  DATA_W  RAM read data, valid the cycle after address is sampled (registered-address RAM).
REQ-017 Port: init_done  output  1  high once zero-fill complete (or immediately if CLEAR_ON_RESET=0).

Function
REQ-018 FSM states: INIT (zero-fill), SERVE; rst enters INIT if CLEAR_ON_RESET else SERVE.
REQ-019 INIT: ram_we=1, ram_wdata=0, ram_addr counts 0..2^ADDR_W-1, one address per cycle; after last address -> SERVE; no grants in INIT.
REQ-020 SERVE: at most one grant per cycle, gnt combinational from req and round-robin pointer.
REQ-021 Only one requester: grant it immediately, same cycle.
REQ-022 Both requesting: grant the requester not granted most recently; pointer updates only on an actual grant.
REQ-023 Granted cycle: ram_addr/ram_we/ram_wdata driven from granted requester; no grant: ram_we=0, ram_addr holds last value.
REQ-024 Granted read in cycle N: ram_rdata sampled at end of N+1, rdata_x updated and rvalid_x=1 in N+2 (latency 2); back-to-back reads pipeline at one per cycle.
REQ-025 Granted write: no rvalid; write takes effect end of grant cycle; read of same address granted N+1 returns new data.
REQ-026 rdata_x holds last value when rvalid_x low.
REQ-027 Grant to same requester on consecutive cycles allowed when other is idle.
REQ-028 Dropping req without grant is legal; no side effects.

Reset
REQ-029 On rst: gnt_*=0, rvalid_*=0, rdata_*=0, ram_we=0, ram_addr=0, ram_wdata=0, pointer favours A, read pipeline flushed.
REQ-030 init_done=0 during rst and INIT; rst asserted mid-INIT restarts sweep at address 0.
REQ-031 rst mid-read: pending rvalid pulses discarded.

Configuration
REQ-032 Macro SPRAM_ARB_STATS_EN defined: adds outputs gcnt_a, gcnt_b (16 bits each), counting grants, saturating at 0xFFFF, cleared by rst.
REQ-033 Macro undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-034 Package spram_arb_pkg holds FSM state enum (INIT, SERVE), requester ID constants (REQ_A=0, REQ_B=1), stats counter width constant (16).
REQ-035 Sub-module rr_arbiter2: two-input round-robin arbiter (req in, one-hot gnt out, pointer register).

Verification
REQ-036 rst then release, CLEAR_ON_RESET=1 -> init_done rises after exactly 64 cycles; ram_we=1 with addresses 0..63, data 0.
REQ-037 A writes 0xDEADBEEF @5, next cycle A reads @5 -> rvalid_a 2 cycles after read grant, rdata_a=0xDEADBEEF.
REQ-038 req_a and req_b held high 6 cycles, reads -> grants alternate A,B,A,B,A,B; no cycle with both grants.
REQ-039 Only req_b high 4 cycles -> gnt_b high all 4 cycles, 4 rvalid_b pulses, consecutive.
REQ-040 rst asserted at INIT address 20 -> sweep restarts at 0, init_done after 64 further cycles.
REQ-041 SPRAM_ARB_STATS_EN defined, 70000 grants to A -> gcnt_a=0xFFFF, gcnt_b=0.
